spi_seq_ctrl: RTL and testbench

//  Command sequencer between the host endpoint wires/triggers and the SPI sensor master.

---
 rtl/spi_seq_ctrl_pkg.sv | 32 +++
 rtl/spi_seq_gap_timer.sv | 39 +++
 rtl/spi_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_spi_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer.
// Contents:
//   seq_state_e     sequencer FSM state encoding
//   TAG_*_LSB       bit offsets of the fields in a readout FIFO word
//   pack_fifo_word  builds {frame[7:0], idx[7:0], rx[15:0]} for the readout FIFO
package spi_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_PUSH  = 3'd4,
      ST_GAP   = 3'd5
   } seq_state_e;

   localparam int TAG_RX_LSB    = 0;
   localparam int TAG_IDX_LSB   = 16;
   localparam int TAG_FRAME_LSB = 24;

   function automatic logic [31:0] pack_fifo_word(input logic [7:0]  frame,
                                                  input logic [7:0]  idx,
                                                  input logic [15:0] rx);
      logic [31:0] word_s;
      word_s = 32'd0;
      word_s[TAG_FRAME_LSB +: 8] = frame;
      word_s[TAG_IDX_LSB   +: 8] = idx;
      word_s[TAG_RX_LSB    +: 16] = rx;
      return word_s;
   endfunction

endpackage

// File: rtl/spi_seq_gap_timer.sv
// Load / countdown / expire timer used to pace the sequencer.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   load        arms the timer with load_val (takes priority over counting)
//   load_val    cycles-1 to wait; expired is high for one cycle after load_val+1 cycles
//   expired     high on the last cycle of the programmed interval
module spi_seq_gap_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_r;
   logic             active_r;

   // Countdown: load arms the timer, it disarms itself on the cycle it expires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r    <= {CNT_W{1'b0}};
         active_r <= 1'b0;
      end else if (load) begin
         cnt_r    <= load_val;
         active_r <= 1'b1;
      end else if (active_r) begin
         if (cnt_r == {CNT_W{1'b0}}) begin
            active_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
      end
   end

   assign expired = active_r && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/spi_seq_ctrl.sv
// Command sequencer between host triggers and the SPI sensor master.
// Walks command RAM entries 0..cmd_last, runs one SPI transfer per entry and
// pushes each tagged MISO word into the readout FIFO. Single-frame or looping.
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   start_trig, stop_trig   1-cycle trigger pulses (stop is graceful)
//   continuous, cmd_last    mode and last command index, latched at start
//   cmd_addr / cmd_data     command RAM read port (1-cycle read latency)
//   spi_start/spi_tx        launch a transfer; spi_busy/spi_done/spi_rx from master
//   fifo_din/fifo_wr_en     readout FIFO write port; fifo_full never stalls us
//   busy, frame_cnt, overflow  status
module spi_seq_ctrl
   import spi_seq_ctrl_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int CMD_ADDR_W = 6,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_trig,
   input  logic                  stop_trig,
   input  logic                  continuous,
   input  logic [CMD_ADDR_W-1:0] cmd_last,
   output logic [CMD_ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0]     cmd_data,
   output logic                  spi_start,
   output logic [DATA_W-1:0]     spi_tx,
   input  logic                  spi_busy,
   input  logic                  spi_done,
   input  logic [DATA_W-1:0]     spi_rx,
   output logic [31:0]           fifo_din,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   output logic                  busy,
   output logic [15:0]           frame_cnt,
   output logic                  overflow
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   seq_state_e            state_r;
   logic [CMD_ADDR_W-1:0] idx_r;
   logic [CMD_ADDR_W-1:0] last_r;
   logic [CMD_ADDR_W-1:0] cmd_addr_r;
   logic                  cont_r;
   logic                  stop_pend_r;
   logic                  spi_start_r;
   logic [DATA_W-1:0]     spi_tx_r;
   logic [31:0]           fifo_din_r;
   logic                  fifo_wr_en_r;
   logic                  busy_r;
   logic [15:0]           frame_cnt_r;
   logic                  overflow_r;
   logic                  gap_load_s;
   logic                  gap_expired_s;

   // Arm the gap timer during the single PUSH cycle so GAP lasts GAP_CYCLES clocks.
   always_comb begin
      gap_load_s = 1'b0;
      if (state_r == ST_PUSH) begin
         gap_load_s = 1'b1;
      end else begin
         gap_load_s = 1'b0;
      end
   end

   spi_seq_gap_timer #(
      .CNT_W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load_s),
      .load_val (GAP_LOAD),
      .expired  (gap_expired_s)
   );

   // Sequencer FSM with its idx / frame counters and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         idx_r        <= {CMD_ADDR_W{1'b0}};
         last_r       <= {CMD_ADDR_W{1'b0}};
         cmd_addr_r   <= {CMD_ADDR_W{1'b0}};
         cont_r       <= 1'b0;
         stop_pend_r  <= 1'b0;
         spi_start_r  <= 1'b0;
         spi_tx_r     <= {DATA_W{1'b0}};
         fifo_din_r   <= 32'd0;
         fifo_wr_en_r <= 1'b0;
         busy_r       <= 1'b0;
         frame_cnt_r  <= 16'd0;
         overflow_r   <= 1'b0;
      end else begin
         spi_start_r  <= 1'b0;
         fifo_wr_en_r <= 1'b0;
         // A stop while running is only remembered; it is acted on at the end of GAP.
         if (stop_trig && (state_r != ST_IDLE)) begin
            stop_pend_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               stop_pend_r <= 1'b0;
               if (start_trig && !stop_trig) begin
                  last_r      <= cmd_last;
                  cont_r      <= continuous;
                  idx_r       <= {CMD_ADDR_W{1'b0}};
                  cmd_addr_r  <= {CMD_ADDR_W{1'b0}};
                  frame_cnt_r <= 16'd0;
                  overflow_r  <= 1'b0;
                  busy_r      <= 1'b1;
                  state_r     <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state_r <= ST_ISSUE;
            end
            ST_ISSUE: begin
               // RAM data is valid here; keep sampling it until the master is free.
               spi_tx_r <= cmd_data;
               if (!spi_busy) begin
                  spi_start_r <= 1'b1;
                  state_r     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The write strobe is registered here so it is presented during PUSH.
               if (spi_done) begin
                  state_r <= ST_PUSH;
                  if (!fifo_full) begin
                     fifo_wr_en_r <= 1'b1;
                     fifo_din_r   <= pack_fifo_word(frame_cnt_r[7:0], 8'(idx_r), spi_rx[15:0]);
                  end else begin
                     overflow_r <= 1'b1;
                  end
               end
            end
            ST_PUSH: begin
               state_r <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_expired_s) begin
                  if (stop_pend_r || stop_trig) begin
                     stop_pend_r <= 1'b0;
                     busy_r      <= 1'b0;
                     state_r     <= ST_IDLE;
                  end else if (idx_r < last_r) begin
                     idx_r      <= idx_r + CMD_ADDR_W'(1);
                     cmd_addr_r <= idx_r + CMD_ADDR_W'(1);
                     state_r    <= ST_FETCH;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + 16'd1;
                     if (cont_r) begin
                        idx_r      <= {CMD_ADDR_W{1'b0}};
                        cmd_addr_r <= {CMD_ADDR_W{1'b0}};
                        state_r    <= ST_FETCH;
                     end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                     end
                  end
               end
            end
            default: begin
               busy_r      <= 1'b0;
               stop_pend_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_addr   = cmd_addr_r;
   assign spi_start  = spi_start_r;
   assign spi_tx     = spi_tx_r;
   assign fifo_din   = fifo_din_r;
   assign fifo_wr_en = fifo_wr_en_r;
   assign busy       = busy_r;
   assign frame_cnt  = frame_cnt_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Self-checking bench for spi_seq_ctrl: random command RAM contents, a
// behavioural SPI master (done 16 clks after start), and a scoreboard that
// predicts every spi_tx word and every tagged FIFO word.
module tb_spi_seq_ctrl;

   localparam int DATA_W     = 16;
   localparam int CMD_ADDR_W = 6;
   localparam int GAP_CYCLES = 4;

   logic                  clk;
   logic                  reset;
   logic                  start_trig;
   logic                  stop_trig;
   logic                  continuous;
   logic [CMD_ADDR_W-1:0] cmd_last;
   logic [CMD_ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0]     cmd_data;
   logic                  spi_start;
   logic [DATA_W-1:0]     spi_tx;
   logic                  spi_busy;
   logic                  spi_done;
   logic [DATA_W-1:0]     spi_rx;
   logic [31:0]           fifo_din;
   logic                  fifo_wr_en;
   logic                  fifo_full;
   logic                  busy;
   logic [15:0]           frame_cnt;
   logic                  overflow;

   int n_vec     = 0;
   int n_err     = 0;
   int n_starts  = 0;
   int n_writes  = 0;
   int cyc       = 0;
   int last_done = -1;
   bit gap_chk   = 1'b0;

   logic [31:0] exp_q[$];
   logic [15:0] exp_tx_q[$];
   logic [15:0] cmd_mem [64];

   logic        m_busy;
   logic        m_done;
   logic [15:0] m_rx;
   logic [15:0] m_tx;
   int          m_cnt;

   spi_seq_ctrl #(
      .DATA_W     (DATA_W),
      .CMD_ADDR_W (CMD_ADDR_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_trig (start_trig),
      .stop_trig  (stop_trig),
      .continuous (continuous),
      .cmd_last   (cmd_last),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .spi_start  (spi_start),
      .spi_tx     (spi_tx),
      .spi_busy   (spi_busy),
      .spi_done   (spi_done),
      .spi_rx     (spi_rx),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Sensor response: a fixed byte-swap/xor of the command word.
   function automatic logic [15:0] rx_of(input logic [15:0] tx);
      return {tx[7:0], tx[15:8]} ^ 16'h3C5A;
   endfunction

   // Command RAM with one clock read latency.
   always @(posedge clk) cmd_data <= cmd_mem[cmd_addr];

   // SPI master model: busy after start, done pulse 16 clks after start.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_rx <= 16'd0; m_tx <= 16'd0;
      end else begin
         m_done <= 1'b0;
         if (spi_start) begin
            m_busy <= 1'b1; m_cnt <= 15; m_tx <= spi_tx;
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_rx <= rx_of(m_tx);
            end
            m_cnt <= m_cnt - 1;
         end
      end
   end
   assign spi_busy = m_busy;
   assign spi_done = m_done;
   assign spi_rx   = m_rx;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every DUT spi_start / fifo write.
   initial begin
      logic [31:0] e;
      logic [15:0] t;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (fifo_wr_en) begin
               n_writes++;
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_write: actual %0h, required no write", fifo_din);
               end else begin
                  e = exp_q.pop_front();
                  chk("fifo_din", fifo_din, e);
               end
            end
            if (spi_start) begin
               n_starts++;
               if (exp_tx_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_start: actual tx %0h, required no start", spi_tx);
               end else begin
                  t = exp_tx_q.pop_front();
                  chk("spi_tx", spi_tx, t);
               end
               if (gap_chk && last_done >= 0)
                  chk("done_to_next_start", cyc - last_done, GAP_CYCLES + 4);
            end
            if (spi_done) last_done = cyc;
         end
      end
   end

   task automatic plan(input int frame, input int idx, input bit wr);
      logic [15:0] tx;
      tx = cmd_mem[idx];
      exp_tx_q.push_back(tx);
      if (wr) exp_q.push_back({8'(frame), 8'(idx), rx_of(tx)});
   endtask

   task automatic start_seq(input int last, input bit cont);
      cmd_last   = CMD_ADDR_W'(last);
      continuous = cont;
      @(posedge clk); #1 start_trig = 1'b1;
      @(posedge clk); #1 start_trig = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_trig = 1'b1;
      @(posedge clk); #1 stop_trig = 1'b0;
   endtask

   task automatic wait_starts(input int target, input int budget);
      int k;
      k = 0;
      while (n_starts < target && k < budget) begin
         @(posedge clk); k++;
      end
      #1;
      chk("start_count_reached", n_starts >= target, 1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      @(posedge clk); #1;
      while (busy && k < budget) begin
         @(posedge clk); #1; k++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("idle_reached", busy, 0);
   endtask

   task automatic new_cmds();
      for (int i = 0; i < 64; i++) cmd_mem[i] = 16'($urandom);
   endtask

   initial begin
      int s0;
      int w0;
      int lat;
      int last;
      reset = 1'b1; start_trig = 1'b0; stop_trig = 1'b0;
      continuous = 1'b0; cmd_last = '0; fifo_full = 1'b0;
      new_cmds();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {cmd_addr, spi_start, spi_tx, fifo_din, fifo_wr_en,
                            busy, frame_cnt, overflow}, 96'd0);
      reset = 1'b0;

      // start and stop together in IDLE: stays idle
      cmd_last = 6'd3; start_trig = 1'b1; stop_trig = 1'b1;
      @(posedge clk); #1 start_trig = 1'b0; stop_trig = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("start_stop_same_cycle_busy", busy, 0);
      chk("start_stop_same_cycle_starts", n_starts, 0);

      // 1: full single frame of 32 commands, start latency 3
      for (int i = 0; i < 32; i++) plan(0, i, 1'b1);
      s0 = n_starts; w0 = n_writes;
      cmd_last = 6'd31; continuous = 1'b0;
      @(posedge clk); #1 start_trig = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 1) start_trig = 1'b0;
         if (spi_start) begin
            lat = k;
            break;
         end
      end
      chk("start_latency", lat, 3);
      chk("busy_running", busy, 1);
      wait_idle(3000);
      chk("t1_writes", n_writes - w0, 32);
      chk("t1_starts", n_starts - s0, 32);
      chk("t1_frame_cnt", frame_cnt, 1);

      // 2: continuous, stop during the 13th transfer -> 13 writes
      new_cmds();
      for (int k = 0; k < 13; k++) plan(k / 5, k % 5, 1'b1);
      s0 = n_starts; w0 = n_writes;
      start_seq(4, 1'b1);
      wait_starts(s0 + 13, 3000);
      pulse_stop();
      wait_idle(500);
      chk("t2_writes", n_writes - w0, 13);
      chk("t2_frame_cnt", frame_cnt, 2);

      // 3: FIFO full during idx 3 -> dropped, overflow sticky
      new_cmds();
      for (int i = 0; i < 8; i++) plan(0, i, i != 3);
      s0 = n_starts; w0 = n_writes;
      start_seq(7, 1'b0);
      chk("t3_overflow_clear", overflow, 0);
      wait_starts(s0 + 4, 500);
      fifo_full = 1'b1;
      wait_starts(s0 + 5, 500);
      fifo_full = 1'b0;
      chk("t3_overflow_set", overflow, 1);
      wait_idle(1000);
      chk("t3_overflow_sticky", overflow, 1);
      chk("t3_writes", n_writes - w0, 7);

      // 4: start_trig during WAIT is ignored
      new_cmds();
      for (int i = 0; i < 6; i++) plan(0, i, 1'b1);
      s0 = n_starts; w0 = n_writes;
      start_seq(5, 1'b0);
      chk("t4_overflow_cleared_by_start", overflow, 0);
      wait_starts(s0 + 2, 500);
      repeat (4) @(posedge clk);
      #1 start_trig = 1'b1;
      @(posedge clk); #1 start_trig = 1'b0;
      wait_idle(1000);
      chk("t4_writes", n_writes - w0, 6);
      chk("t4_frame_cnt", frame_cnt, 1);

      // 5: reset mid-WAIT, then restart from idx 0 / frame 0
      new_cmds();
      plan(0, 0, 1'b1); plan(0, 1, 1'b1); plan(1, 0, 1'b1);
      s0 = n_starts;
      start_seq(1, 1'b1);
      wait_starts(s0 + 3, 500);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_frame_cnt_before_reset", frame_cnt, 1);
      reset = 1'b1;
      #1;
      chk("t5_async_reset_outputs", {cmd_addr, spi_start, spi_tx, fifo_din, fifo_wr_en,
                                     busy, frame_cnt, overflow}, 96'd0);
      chk("t5_pending_writes", exp_q.size(), 1);
      exp_q.delete(); exp_tx_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) plan(0, i, 1'b1);
      w0 = n_writes;
      start_seq(2, 1'b0);
      chk("t5_restart_frame_cnt", frame_cnt, 0);
      chk("t5_restart_addr", cmd_addr, 0);
      wait_idle(1000);
      chk("t5_writes", n_writes - w0, 3);
      chk("t5_frame_cnt", frame_cnt, 1);

      // 6: one command per frame, looping; frame tags 0..3 and fixed gap
      new_cmds();
      for (int f = 0; f < 4; f++) plan(f, 0, 1'b1);
      s0 = n_starts; w0 = n_writes;
      last_done = -1; gap_chk = 1'b1;
      start_seq(0, 1'b1);
      wait_starts(s0 + 4, 500);
      pulse_stop();
      wait_idle(500);
      gap_chk = 1'b0;
      chk("t6_writes", n_writes - w0, 4);

      // 7: random frame lengths, single frame
      for (int r = 0; r < 3; r++) begin
         new_cmds();
         last = $urandom_range(0, 12);
         for (int i = 0; i <= last; i++) plan(0, i, 1'b1);
         w0 = n_writes;
         start_seq(last, 1'b0);
         wait_idle(2000);
         chk("t7_writes", n_writes - w0, last + 1);
         chk("t7_frame_cnt", frame_cnt, 1);
      end

      chk("fifo_queue_drained", exp_q.size(), 0);
      chk("tx_queue_drained", exp_tx_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
